// File: rtl/video_cfg_bank_if.sv
// Register bus between the MCU and the video configuration bank.
// The master drives writes and addresses; the slave returns combinational read data.
interface video_cfg_bank_if #(
  parameter int AW = 6
);
  logic [31:0]   reg_wdata;
  logic [AW+1:0] reg_addr;
  logic          reg_wstrobe;
  logic [31:0]   reg_rdata;

  modport master (output reg_wdata, output reg_addr, output reg_wstrobe, input reg_rdata);
  modport slave  (input reg_wdata, input reg_addr, input reg_wstrobe, output reg_rdata);
endinterface

// File: rtl/video_cfg_bank.sv
// Double-buffered video configuration bank: shadow registers are copied to the active set on a
// frame-aligned or immediate commit, followed by a four-phase req/ack handshake with the pixel domain.
module video_cfg_bank #(
  parameter int NREGS   = 12,
  parameter int DW      = 16,
  parameter int AW      = 6,
  parameter int TIMEOUT = 65535
) (
  input  logic                clk,
  input  logic                reset,
  video_cfg_bank_if.slave     bus,
  input  logic                sync_flybk,
  input  logic                cfg_ack,
  output logic                cfg_req,
  output logic [NREGS*DW-1:0] cfg_active,
  output logic                busy
);

  localparam int            CW         = $clog2(TIMEOUT);
  localparam logic [AW-1:0] CTRL_IDX   = AW'(NREGS);
  localparam logic [CW-1:0] PHASE_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, WAIT_FLYBK, REQ, RELEASE} state_t;

  state_t        state, next_state;
  logic [AW-1:0] word_idx;
  logic [DW-1:0] shadow [NREGS];
  logic          flybk_meta, flybk_s, flybk_prev;
  logic          ack_meta, ack_s;
  logic [CW-1:0] phase_cnt;
  logic [7:0]    count;
  logic          timeout_flag;
  logic          ctrl_wr, commit_req, flybk_rise, phase_expired;
  logic          load_active, req_clr, phase_clr, phase_inc, count_inc, timeout_set;
  logic [31:0]   rdata;
  logic          unused_bits;

  assign word_idx      = bus.reg_addr[AW+1:2];
  assign ctrl_wr       = bus.reg_wstrobe && (word_idx == CTRL_IDX);
  assign commit_req    = ctrl_wr && bus.reg_wdata[0];
  assign flybk_rise    = flybk_s & ~flybk_prev;
  assign phase_expired = (phase_cnt == PHASE_LAST);
  assign unused_bits   = ^{bus.reg_addr[1:0], bus.reg_wdata};

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // Commits are only honoured from IDLE, which is what locks out a second commit while busy.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:       if (commit_req) next_state = bus.reg_wdata[1] ? REQ : WAIT_FLYBK;
      WAIT_FLYBK: if (flybk_rise) next_state = REQ;
      REQ:        if (ack_s) next_state = RELEASE;
                  else if (phase_expired) next_state = IDLE;
      RELEASE:    if (!ack_s) next_state = IDLE;
                  else if (phase_expired) next_state = IDLE;
      default:    next_state = IDLE;
    endcase
  end

  always_comb begin
    busy        = (state != IDLE);
    load_active = (next_state == REQ) && (state != REQ);
    req_clr     = (state == REQ) && (next_state != REQ);
    phase_clr   = load_active || ((state == REQ) && ack_s);
    phase_inc   = ((state == REQ) || (state == RELEASE)) && !phase_expired;
    count_inc   = (state == RELEASE) && !ack_s;
    timeout_set = phase_expired &&
                  (((state == REQ) && !ack_s) || ((state == RELEASE) && ack_s));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) shadow[i] <= '0;
      cfg_active   <= '0;
      cfg_req      <= 1'b0;
      flybk_meta   <= 1'b0;
      flybk_s      <= 1'b0;
      flybk_prev   <= 1'b0;
      ack_meta     <= 1'b0;
      ack_s        <= 1'b0;
      phase_cnt    <= '0;
      count        <= '0;
      timeout_flag <= 1'b0;
    end else begin
      flybk_meta <= sync_flybk;
      flybk_s    <= flybk_meta;
      flybk_prev <= flybk_s;
      ack_meta   <= cfg_ack;
      ack_s      <= ack_meta;

      if (bus.reg_wstrobe) begin
        for (int i = 0; i < NREGS; i++)
          if (word_idx == AW'(i)) shadow[i] <= bus.reg_wdata[DW-1:0];
      end

      if (load_active) begin
        for (int i = 0; i < NREGS; i++) cfg_active[i*DW +: DW] <= shadow[i];
      end

      if (load_active)  cfg_req <= 1'b1;
      else if (req_clr) cfg_req <= 1'b0;

      if (phase_clr)      phase_cnt <= '0;
      else if (phase_inc) phase_cnt <= phase_cnt + 1'b1;

      if (count_inc) count <= count + 8'd1;

      // A timeout landing on the same edge as a clear write keeps the sticky set.
      if (timeout_set)                       timeout_flag <= 1'b1;
      else if (ctrl_wr && bus.reg_wdata[3])  timeout_flag <= 1'b0;
    end
  end

  always_comb begin
    rdata = 32'h0;
    if (word_idx == CTRL_IDX)
      rdata = {16'h0, count, 4'h0, timeout_flag, flybk_s, ack_s, busy};
    for (int i = 0; i < NREGS; i++)
      if (word_idx == AW'(i)) rdata = 32'(shadow[i]);
  end

  assign bus.reg_rdata = rdata;

endmodule

// File: tb/tb_video_cfg_bank.sv
// Self-checking bench for video_cfg_bank: table-driven register access plus hand-written
// commit, flyback, lockout, timeout, reset and counter-wrap sequences, all checked through a scoreboard.
module tb_video_cfg_bank;

  localparam int            NREGS   = 12;
  localparam int            DW      = 16;
  localparam int            AW      = 6;
  localparam int            TIMEOUT = 16;
  localparam logic [AW-1:0] CTRL_W  = 6'd12;

  typedef struct {
    bit          wr;
    logic [AW-1:0] w;
    logic [31:0] data;
    logic [31:0] exp;
  } vec_t;

  logic                clk;
  logic                reset;
  logic                sync_flybk;
  logic                cfg_ack;
  logic                cfg_req;
  logic                busy;
  logic [NREGS*DW-1:0] cfg_active;

  video_cfg_bank_if #(.AW(AW)) bus();

  video_cfg_bank #(.NREGS(NREGS), .DW(DW), .AW(AW), .TIMEOUT(TIMEOUT)) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus),
    .sync_flybk (sync_flybk),
    .cfg_ack    (cfg_ack),
    .cfg_req    (cfg_req),
    .cfg_active (cfg_active),
    .busy       (busy)
  );

  int          pass_cnt  = 0;
  int          total_cnt = 0;
  string       name_q[$];
  logic [31:0] exp_q[$];
  vec_t        vecs[10];
  logic [31:0] rd;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish, got running, expected done");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [31:0] statusWord(input logic [7:0] cnt, input bit tmo,
                                             input bit flybk, input bit ack, input bit bsy);
    return {16'h0, cnt, 4'h0, tmo, flybk, ack, bsy};
  endfunction

  function automatic logic [31:0] activeReg(input int i);
    return 32'(cfg_active[i*DW +: DW]);
  endfunction

  task automatic expectValue(input string name, input logic [31:0] value);
    name_q.push_back(name);
    exp_q.push_back(value);
  endtask

  task automatic checkOutput(input logic [31:0] actual);
    string       name;
    logic [31:0] exp;
    total_cnt++;
    if (exp_q.size() == 0) begin
      $display("[TB] FAIL scoreboard_empty: got %h, expected a queued value", actual);
      return;
    end
    name = name_q.pop_front();
    exp  = exp_q.pop_front();
    if (actual === exp) pass_cnt++;
    else $display("[TB] FAIL %s: got %h, expected %h", name, actual, exp);
  endtask

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] exp);
    expectValue(name, exp);
    checkOutput(actual);
  endtask

  task automatic boundFail(input string name);
    total_cnt++;
    $display("[TB] FAIL %s: got no response, expected one within the cycle budget", name);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic busWrite(input logic [AW-1:0] w, input logic [31:0] data);
    bus.reg_addr    = {w, 2'b00};
    bus.reg_wdata   = data;
    bus.reg_wstrobe = 1'b1;
    @(posedge clk);
    #1;
    bus.reg_wstrobe = 1'b0;
  endtask

  task automatic readWord(input logic [AW-1:0] w, output logic [31:0] data);
    bus.reg_addr = {w, 2'b00};
    #1;
    data = bus.reg_rdata;
  endtask

  task automatic applyStimulus(input vec_t v, input int idx);
    if (v.wr) begin
      busWrite(v.w, v.data);
    end else begin
      bus.reg_addr = {v.w, 2'b00};
      expectValue($sformatf("vec%0d_rd_w%0d", idx, v.w), v.exp);
      #1;
      checkOutput(bus.reg_rdata);
    end
  endtask

  task automatic waitReq(input logic level, input string name);
    int n = 0;
    while (cfg_req !== level && n < 40) begin
      tick();
      n++;
    end
    if (cfg_req !== level) boundFail(name);
  endtask

  task automatic waitIdle(input string name);
    int n = 0;
    while (busy !== 1'b0 && n < 40) begin
      tick();
      n++;
    end
    if (busy !== 1'b0) boundFail(name);
  endtask

  task automatic handshake(input string name);
    cfg_ack = 1'b1;
    waitReq(1'b0, {name, "_req_fall"});
    cfg_ack = 1'b0;
    waitIdle({name, "_idle"});
  endtask

  initial begin
    int extra;

    reset           = 1'b1;
    sync_flybk      = 1'b0;
    cfg_ack         = 1'b0;
    bus.reg_addr    = '0;
    bus.reg_wdata   = '0;
    bus.reg_wstrobe = 1'b0;
    repeat (3) tick();
    check("reset_req", 32'(cfg_req), 32'h0);
    check("reset_busy", 32'(busy), 32'h0);
    check("reset_active", 32'(|cfg_active), 32'h0);
    reset = 1'b0;
    tick();

    for (int w = 0; w < 16; w++) begin
      readWord(AW'(w), rd);
      check($sformatf("reset_rd_w%0d", w), rd, 32'h0);
    end

    vecs[0] = '{wr: 1'b1, w: 6'd3,  data: 32'h0001_ABCD, exp: 32'h0};
    vecs[1] = '{wr: 1'b0, w: 6'd3,  data: 32'h0,         exp: 32'h0000_ABCD};
    vecs[2] = '{wr: 1'b1, w: 6'd0,  data: 32'hFFFF_1234, exp: 32'h0};
    vecs[3] = '{wr: 1'b0, w: 6'd0,  data: 32'h0,         exp: 32'h0000_1234};
    vecs[4] = '{wr: 1'b1, w: 6'd11, data: 32'h0000_8000, exp: 32'h0};
    vecs[5] = '{wr: 1'b0, w: 6'd11, data: 32'h0,         exp: 32'h0000_8000};
    vecs[6] = '{wr: 1'b1, w: 6'd13, data: 32'hDEAD_BEEF, exp: 32'h0};
    vecs[7] = '{wr: 1'b0, w: 6'd13, data: 32'h0,         exp: 32'h0};
    vecs[8] = '{wr: 1'b1, w: 6'd0,  data: 32'd640,       exp: 32'h0};
    vecs[9] = '{wr: 1'b0, w: 6'd63, data: 32'h0,         exp: 32'h0};
    for (int i = 0; i < 10; i++) applyStimulus(vecs[i], i);
    readWord(6'd0, rd);
    check("shadow0_640", rd, 32'd640);
    check("active_untouched", 32'(|cfg_active), 32'h0);

    // Immediate commit and manual four-phase handshake
    busWrite(CTRL_W, 32'h3);
    check("imm_active0", activeReg(0), 32'd640);
    check("imm_active3", activeReg(3), 32'h0000_ABCD);
    check("imm_active11", activeReg(11), 32'h0000_8000);
    check("imm_req", 32'(cfg_req), 32'h1);
    check("imm_busy", 32'(busy), 32'h1);
    repeat (5) tick();
    cfg_ack = 1'b1;
    tick();
    check("ack_req_k", 32'(cfg_req), 32'h1);
    tick();
    check("ack_req_k1", 32'(cfg_req), 32'h1);
    readWord(CTRL_W, rd);
    check("ack_status", rd, statusWord(8'd0, 1'b0, 1'b0, 1'b1, 1'b1));
    tick();
    check("ack_req_k2", 32'(cfg_req), 32'h0);
    check("release_busy", 32'(busy), 32'h1);
    repeat (5) tick();
    cfg_ack = 1'b0;
    tick();
    check("rel_busy_1", 32'(busy), 32'h1);
    tick();
    check("rel_busy_2", 32'(busy), 32'h1);
    tick();
    check("rel_busy_3", 32'(busy), 32'h0);
    readWord(CTRL_W, rd);
    check("imm_count", rd, statusWord(8'd1, 1'b0, 1'b0, 1'b0, 1'b0));

    // Flyback-aligned commit
    busWrite(6'd0, 32'd800);
    busWrite(CTRL_W, 32'h1);
    check("fly_busy", 32'(busy), 32'h1);
    repeat (100) tick();
    check("fly_wait_req", 32'(cfg_req), 32'h0);
    check("fly_wait_active", activeReg(0), 32'd640);
    check("fly_wait_busy", 32'(busy), 32'h1);
    sync_flybk = 1'b1;
    tick();
    check("fly_req_e1", 32'(cfg_req), 32'h0);
    tick();
    check("fly_req_e2", 32'(cfg_req), 32'h0);
    tick();
    check("fly_req_e3", 32'(cfg_req), 32'h1);
    check("fly_active0", activeReg(0), 32'd800);
    handshake("fly_hs");
    readWord(CTRL_W, rd);
    check("fly_status", rd, statusWord(8'd2, 1'b0, 1'b1, 1'b0, 1'b0));
    sync_flybk = 1'b0;
    repeat (3) tick();

    // Second commit while waiting for flyback is ignored
    busWrite(6'd1, 32'd111);
    busWrite(CTRL_W, 32'h1);
    busWrite(6'd1, 32'd222);
    busWrite(CTRL_W, 32'h1);
    repeat (5) tick();
    check("lock_req_pre", 32'(cfg_req), 32'h0);
    sync_flybk = 1'b1;
    waitReq(1'b1, "lock_req_rise");
    check("lock_active1", activeReg(1), 32'd222);
    handshake("lock_hs");
    extra = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (cfg_req || busy) extra++;
    end
    check("lock_single_hs", 32'(extra), 32'h0);
    sync_flybk = 1'b0;
    repeat (3) tick();
    readWord(CTRL_W, rd);
    check("lock_count", rd, statusWord(8'd3, 1'b0, 1'b0, 1'b0, 1'b0));

    // Handshake timeout with no ack
    busWrite(CTRL_W, 32'h3);
    repeat (15) tick();
    check("tmo_req_15", 32'(cfg_req), 32'h1);
    tick();
    check("tmo_req_16", 32'(cfg_req), 32'h0);
    check("tmo_busy", 32'(busy), 32'h0);
    check("tmo_active_kept", activeReg(1), 32'd222);
    readWord(CTRL_W, rd);
    check("tmo_status", rd, statusWord(8'd3, 1'b1, 1'b0, 1'b0, 1'b0));
    busWrite(CTRL_W, 32'h8);
    readWord(CTRL_W, rd);
    check("tmo_cleared", rd, statusWord(8'd3, 1'b0, 1'b0, 1'b0, 1'b0));

    // Clear write on the timeout edge loses to the set
    busWrite(CTRL_W, 32'h3);
    repeat (15) tick();
    busWrite(CTRL_W, 32'h8);
    readWord(CTRL_W, rd);
    check("tmo_set_wins", rd, statusWord(8'd3, 1'b1, 1'b0, 1'b0, 1'b0));
    busWrite(CTRL_W, 32'h8);

    // Reset in the middle of a handshake
    busWrite(CTRL_W, 32'h3);
    tick();
    check("mid_req", 32'(cfg_req), 32'h1);
    reset = 1'b1;
    tick();
    check("mid_rst_req", 32'(cfg_req), 32'h0);
    check("mid_rst_busy", 32'(busy), 32'h0);
    reset = 1'b0;
    tick();
    readWord(CTRL_W, rd);
    check("mid_rst_status", rd, 32'h0);
    check("mid_rst_active", 32'(|cfg_active), 32'h0);

    // Commit counter wraps after 256 handshakes
    for (int i = 0; i < 256; i++) begin
      busWrite(CTRL_W, 32'h3);
      handshake("wrap_hs");
      if (i == 0 || i == 254) begin
        readWord(CTRL_W, rd);
        check($sformatf("wrap_count_%0d", i + 1), rd,
              statusWord(8'(i + 1), 1'b0, 1'b0, 1'b0, 1'b0));
      end
    end
    readWord(CTRL_W, rd);
    check("wrap_count_256", rd, statusWord(8'd0, 1'b0, 1'b0, 1'b0, 1'b0));

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/video_cfg_bank.md
# video_cfg_bank

Parametrised, double-buffered configuration register bank for the output video path. The MCU writes `NREGS` shadow registers over the 32-bit register bus, then requests a commit. The block waits for the start of VIDC vertical flyback, or commits immediately if asked. It copies shadow to active and performs a four-phase req/ack handshake with the pixel-domain consumer, so timing changes never land mid-frame. It generalises the earlier fixed timing register set with arbitrary register count and width, frame-aligned commits, a handshake timeout and a commit counter.

## Interface
Parameters:
- `NREGS`, 12, number of shadow/active configuration registers (1..62).
- `DW`, 16, width of each configuration register (1..32).
- `AW`, 6, word-address width; requires 2^AW ≥ NREGS+1.
- `TIMEOUT`, 65535, cycles allowed per handshake phase before abort (≥ 4).

Ports:
- `clk`  in  1  bank clock.
- `reset`  in  1  reset, synchronous, active-high.
- `reg_wdata`  in  32  register write data.
- `reg_addr`  in  AW+2  byte address; bits [1:0] are ignored.
- `reg_wstrobe`  in  1  one-cycle write strobe.
- `reg_rdata`  out  32  combinational read data.
- `sync_flybk`  in  1  asynchronous VIDC flyback level.
- `cfg_ack`  in  1  asynchronous acknowledge from the pixel domain.
- `cfg_req`  out  1  registered commit request to the pixel domain.
- `cfg_active`  out  NREGS*DW  active registers, flattened; register i occupies bits [i*DW +: DW].
- `busy`  out  1  high whenever the FSM is not in IDLE.

## Operation
- Word index `w = reg_addr[AW+1:2]`.
- **Shadow writes** (`w < NREGS`): `shadow[w] <= reg_wdata[DW-1:0]`. Writes are accepted in every state and never touch the active registers.
- **Control write** (`w == NREGS`):
  - bit0 = commit; bit1 = immediate (valid only together with commit); bit3 = write-1-to-clear timeout sticky.
  - A commit written while `busy` is ignored. Bit3 still takes effect.
- **Reads:**
  - `w < NREGS`: shadow value, zero-extended.
  - `w == NREGS`: {count[7:0] at bits [15:8], timeout at bit3, flybk_s at bit2, ack_s at bit1, busy at bit0}, all other bits zero.
  - Other addresses read 0.
- **Synchronisers:** `sync_flybk` and `cfg_ack` each pass through 2 flops, giving `flybk_s` and `ack_s`. `flybk_prev` holds the previous `flybk_s`. A flyback rise is `flybk_s & ~flybk_prev`.
- **FSM:**
  - IDLE
    - On commit without immediate, go to WAIT_FLYBK.
    - On commit with immediate, go to REQ.
  - WAIT_FLYBK
    - On a flyback rise, go to REQ. There is no timeout in this state.
  - Entry to REQ
    - Copy every shadow register to `cfg_active`, in the same edge as the state change.
    - Set `cfg_req = 1`.
    - Clear the phase counter.
  - REQ
    - When `ack_s` is 1, set `cfg_req = 0`, clear the counter and go to RELEASE.
  - RELEASE
    - When `ack_s` is 0, go to IDLE.
    - Increment `count`, an 8-bit counter that wraps at 255→0.
  - Timeout
    - Applies in REQ and RELEASE.
    - When the counter reaches TIMEOUT-1 without the awaited ack level: set the timeout sticky, set `cfg_req = 0` and go to IDLE.
    - `count` is not incremented.
    - `cfg_active` keeps the already-copied values.
- **Simultaneous timeout and clear:** if a timeout sets the sticky in the same cycle as a bit3 clear write, set wins.
- **Reset:** a mid-handshake reset returns to IDLE and drops `cfg_req` immediately. The consumer must tolerate a req that vanishes.

## Timing
- **Reset values:**
  - All shadow registers = 0; `cfg_active` = 0.
  - `cfg_req` = 0, `busy` = 0, `count` = 0, timeout sticky = 0.
  - Synchroniser flops = 0; state = IDLE.
- **Commit strobe** at edge N:
  - `busy` = 1 after edge N.
  - With immediate: `cfg_active` updated and `cfg_req` = 1 after edge N.
- **Flyback:** an input rising just before edge M is detected at edge M+1. `cfg_active` and `cfg_req` update at edge M+2.
- **Ack:** an ack rising before edge K gives `ack_s` after edge K+1. `cfg_req` falls at edge K+2.
- **Ack fall:** `ack_s` falls, then IDLE, `busy = 0` and `count+1` follow on the next edge.
- `reg_rdata` is purely combinational from `reg_addr` and current state, with zero wait states.

## Test plan
- **Reset and read-back:** after reset, read all addresses and confirm they return 0. Write shadow[3] = 0x1ABCD with DW=16, read it back and confirm 0xABCD. Confirm `cfg_active` is still 0.
- **Immediate commit:** write shadow[0] = 640, then write control 0x3. At the next edge require `cfg_active[15:0] = 640` and `cfg_req = 1`. Bench acks after 5 cycles and releases after 5 more. Require `busy` to fall and the status read to show count = 1.
- **Flyback-aligned commit:** write control 0x1 with `sync_flybk` low for 100 cycles. Require `cfg_active` unchanged and `cfg_req = 0`. Raise `sync_flybk`. Require `cfg_req = 1` exactly 3 edges later.
- **Busy lockout:** issue a commit, change shadow[1] and issue a second commit while in WAIT_FLYBK. After the flyback, exactly one handshake occurs and `cfg_active` carries the new shadow[1]. The count increments by 1 only.
- **Timeout:** set TIMEOUT = 16 and never ack. After the immediate commit require `cfg_req` to drop after 16 cycles, status bit3 = 1, `busy` = 0 and count unchanged. Write 0x8 and confirm bit3 reads 0.
- **Mid-operation reset and wrap:** assert `reset` while in REQ and require `cfg_req = 0` and `busy = 0` next cycle. Separately, perform 256 handshakes and confirm count wraps to 0.
